alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue and writeback stage that sits directly upstream of the ALU. It accepts one operation request at a time through a valid/ready handshake, drives `operand1`, `operand2` and `ALU_sel`, and holds them stable for a fixed settle window so the ALU's registered result and flags become consistent. It then captures result, flags and compare outputs into architectural registers and issues a single register-file write strobe.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 3: clock edges the ALU inputs are held before capture. Legal minimum is 3 (result, then flags, then CMP eq/gt/lt).
- `REG_ADDR_W`, default 3: width of the destination register index.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request (IDLE only).
- `req_op`  in  8  ALU opcode.
- `req_a`  in  8  operand A.
- `req_b`  in  8  operand B.
- `req_dst`  in  REG_ADDR_W  destination register index.
- `operand1`  out  8  to ALU.
- `operand2`  out  8  to ALU.
- `ALU_sel`  out  8  to ALU.
- `alu_result`  in  8  ALU `operation_result`.
- `alu_flags`  in  7  ALU `Flags` (0 Z, 1 C, 2 S, 3 P, 4 I, 5 D, 6 V).
- `alu_eq`, `alu_gt`, `alu_lt`  in  1 each  ALU compare outputs.
- `wb_en`  out  1  register-file write strobe, one-cycle pulse.
- `wb_addr`  out  REG_ADDR_W  write index.
- `wb_data`  out  8  write data.
- `flags_q`  out  7  architectural flags register.
- `cmp_q`  out  3  {eq, gt, lt} register.
- `done`  out  1  one-cycle completion pulse, including illegal ops.
- `err`  out  1  one-cycle pulse with `done` when the op is illegal.

## Operation
- States: IDLE, DRIVE, CAPTURE.
- IDLE:
  - `req_ready`=1 and `ALU_sel`=NOP (8'h00).
  - On `req_valid & req_ready`, latch op/a/b/dst.
  - Legal op: go to DRIVE with the settle counter = SETTLE_CYCLES-1.
  - Illegal op: pulse `done`+`err` next cycle, no register updates, stay in IDLE.
- DRIVE:
  - `operand1`/`operand2`/`ALU_sel` driven from latched values, stable every cycle.
  - Counter decrements each cycle; at 0, go to CAPTURE.
  - `req_valid` is ignored (`req_ready`=0).
- CAPTURE, single cycle:
  - `flags_q`←`alu_flags`.
  - For CMP: `cmp_q`←{alu_eq, alu_gt, alu_lt}, and no writeback.
  - For all other legal ops: `wb_en`=1, `wb_addr`=latched dst, `wb_data`=`alu_result`; `cmp_q` is unchanged.
  - Pulse `done`, return to IDLE, drive `ALU_sel`=NOP from that cycle.
- Legal opcodes: ADD 03, SUB 04, MULT 05, DIV 06, MOD 07, AND 08, OR 09, NOT 0A, NOR 0D, NAND 0E, XNOR 0F, INC 10, XOR 11, DEC 12, SL 14, SR 15, ROL 16, ROR 17, CMP 18. Anything else is illegal.
- Operands remain at their last issued values while in IDLE; only `ALU_sel` returns to NOP.

## Timing
- Reset values:
  - `req_ready`=1.
  - `operand1`, `operand2`, `ALU_sel` = 0.
  - `wb_en`, `wb_addr`, `wb_data` = 0.
  - `flags_q`=7'b0001001 (Z and P set, matching the ALU's idle flags).
  - `cmp_q`, `done`, `err` = 0.
  - State = IDLE.
- Latency, legal op: accept edge T; ALU inputs valid from T; capture edge at T+SETTLE_CYCLES.
  - `wb_en`/`done` are high in the cycle after the capture edge, i.e. from T+SETTLE_CYCLES to T+SETTLE_CYCLES+1.
  - Next accept is possible at T+SETTLE_CYCLES+1, so throughput is 1 op per SETTLE_CYCLES+1 cycles.
- Illegal op: `done`/`err` high for the cycle after the accept edge; next accept is possible on the following edge.
- Reset asserted mid-operation aborts immediately: no `wb_en`, no `done`, all outputs return to reset values.
- `req_*` changing while not ready has no effect.
- `wb_en` and `done` are never high for more than one cycle per op.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams (including NOP=8'h00).
  - Flag bit indices (Z=0 … V=6).
  - State encoding.
  - Function `is_legal_op` and `is_cmp_op`.
- Sub-module `alu_sequencer_tb_top` (verification only) wraps the sequencer plus a real ALU instance.
- The RTL itself is one module. The settle counter is $clog2(SETTLE_CYCLES) bits wide.

## Test plan
- ADD a=8'h05 b=8'h03 dst=2 → one `wb_en` pulse at accept+3: `wb_addr`=2, `wb_data`=8'h08; `flags_q`[0]=0, [1]=0, [6]=0.
- ADD a=8'hFF b=8'h01 dst=1 → `wb_data`=8'h00, `flags_q`[0]=1, `flags_q`[1]=1.
- CMP a=8'h07 b=8'h07 → no `wb_en`; `done` pulse; `cmp_q` equals ALU {eq,gt,lt} sampled at the capture edge; `flags_q`[0]=1.
- req_op=8'h01 → `done`=`err`=1 for one cycle, no `wb_en`, `flags_q` unchanged, `req_ready` back to 1 next cycle.
- Back-to-back: `req_valid` held high with INC a=8'h7F then DEC a=8'h00 → exactly two `wb_en` pulses 4 cycles apart, `wb_data`=8'h80 then 8'hFF.
- `rst_n` low for one cycle during DRIVE of SUB → no `wb_en`/`done`, all outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes, flag bit
// positions, sequencer state encoding and opcode classification helpers.
package alu_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FLAGS_W = 7;
  localparam int unsigned CMP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
  localparam logic [OP_W-1:0] OP_ADD  = 8'h03;
  localparam logic [OP_W-1:0] OP_SUB  = 8'h04;
  localparam logic [OP_W-1:0] OP_MULT = 8'h05;
  localparam logic [OP_W-1:0] OP_DIV  = 8'h06;
  localparam logic [OP_W-1:0] OP_MOD  = 8'h07;
  localparam logic [OP_W-1:0] OP_AND  = 8'h08;
  localparam logic [OP_W-1:0] OP_OR   = 8'h09;
  localparam logic [OP_W-1:0] OP_NOT  = 8'h0A;
  localparam logic [OP_W-1:0] OP_NOR  = 8'h0D;
  localparam logic [OP_W-1:0] OP_NAND = 8'h0E;
  localparam logic [OP_W-1:0] OP_XNOR = 8'h0F;
  localparam logic [OP_W-1:0] OP_INC  = 8'h10;
  localparam logic [OP_W-1:0] OP_XOR  = 8'h11;
  localparam logic [OP_W-1:0] OP_DEC  = 8'h12;
  localparam logic [OP_W-1:0] OP_SL   = 8'h14;
  localparam logic [OP_W-1:0] OP_SR   = 8'h15;
  localparam logic [OP_W-1:0] OP_ROL  = 8'h16;
  localparam logic [OP_W-1:0] OP_ROR  = 8'h17;
  localparam logic [OP_W-1:0] OP_CMP  = 8'h18;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_P = 3;
  localparam int unsigned FLAG_I = 4;
  localparam int unsigned FLAG_D = 5;
  localparam int unsigned FLAG_V = 6;

  // ALU idle flags: result 0 gives Z and even parity.
  localparam logic [FLAGS_W-1:0] FLAGS_RESET = 7'b0001001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT,
      OP_NOR, OP_NAND, OP_XNOR, OP_INC, OP_XOR, OP_DEC, OP_SL, OP_SR,
      OP_ROL, OP_ROR, OP_CMP: is_legal_op = 1'b1;
      default:                is_legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_cmp_op(input logic [OP_W-1:0] op);
    is_cmp_op = (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Issue/writeback stage in front of the ALU. Accepts one request via
// valid/ready, holds operands and opcode stable for SETTLE_CYCLES edges,
// then captures result/flags/compare bits and pulses a register write.
// Ports: clk/rst_n; req_valid/req_ready/req_op/req_a/req_b/req_dst request;
// operand1/operand2/ALU_sel to ALU; alu_result/alu_flags/alu_eq/gt/lt from
// ALU; wb_en/wb_addr/wb_data register write; flags_q/cmp_q architectural
// state; done/err completion pulses.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned REG_ADDR_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_W-1:0]       req_op,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  input  logic [REG_ADDR_W-1:0] req_dst,
  output logic [DATA_W-1:0]     operand1,
  output logic [DATA_W-1:0]     operand2,
  output logic [OP_W-1:0]       ALU_sel,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [FLAGS_W-1:0]    alu_flags,
  input  logic                  alu_eq,
  input  logic                  alu_gt,
  input  logic                  alu_lt,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [FLAGS_W-1:0]    flags_q,
  output logic [CMP_W-1:0]      cmp_q,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic [DATA_W-1:0]       op1_q, op1_d;
  logic [DATA_W-1:0]       op2_q, op2_d;
  logic [OP_W-1:0]         alu_sel_q, alu_sel_d;
  logic [REG_ADDR_W-1:0]   dst_q, dst_d;
  logic                    wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]       wb_data_q, wb_data_d;
  logic [FLAGS_W-1:0]      flags_reg_q, flags_reg_d;
  logic [CMP_W-1:0]        cmp_reg_q, cmp_reg_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Next-state and output logic; alu_sel_q doubles as the latched opcode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    alu_sel_d   = alu_sel_q;
    dst_d       = dst_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    flags_reg_d = flags_reg_q;
    cmp_reg_d   = cmp_reg_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (is_legal_op(req_op)) begin
            op1_d     = req_a;
            op2_d     = req_b;
            alu_sel_d = req_op;
            dst_d     = req_dst;
            cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
            state_d   = ST_DRIVE;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        // Leaving when the count reaches 0 puts the capture on edge T+SETTLE.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        flags_reg_d = alu_flags;
        if (is_cmp_op(alu_sel_q)) begin
          cmp_reg_d = {alu_eq, alu_gt, alu_lt};
        end else begin
          wb_en_d   = 1'b1;
          wb_addr_d = dst_q;
          wb_data_d = alu_result;
        end
        done_d    = 1'b1;
        alu_sel_d = OP_NOP;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        alu_sel_d = OP_NOP;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_sel_q   <= OP_NOP;
      dst_q       <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      flags_reg_q <= FLAGS_RESET;
      cmp_reg_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_sel_q   <= alu_sel_d;
      dst_q       <= dst_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      flags_reg_q <= flags_reg_d;
      cmp_reg_q   <= cmp_reg_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign operand1  = op1_q;
  assign operand2  = op2_q;
  assign ALU_sel   = alu_sel_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign flags_q   = flags_reg_q;
  assign cmp_q     = cmp_reg_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small registered ALU model
// (ADD/SUB/INC/DEC/CMP) feeding the result, flag and compare inputs.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_op = 8'h00;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [2:0] req_dst = 3'd0;
  logic [7:0] operand1, operand2, ALU_sel;
  logic [7:0] alu_result;
  logic [6:0] alu_flags;
  logic       alu_eq, alu_gt, alu_lt;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [6:0] flags_q;
  logic [2:0] cmp_q;
  logic       done, err;

  int cyc = 0;
  int wb_seen = 0;
  int done_seen = 0;
  int checks = 0;
  int passed = 0;
  int accept_cyc = 0;

  alu_sequencer #(.SETTLE_CYCLES(3), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
    .operand1(operand1), .operand2(operand2), .ALU_sel(ALU_sel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags_q(flags_q), .cmp_q(cmp_q), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wb_en) wb_seen <= wb_seen + 1;
    if (done)  done_seen <= done_seen + 1;
  end

  // ALU stand-in: combinational function registered on each edge.
  logic [8:0] m_sum;
  logic [7:0] m_res;
  logic       m_v;
  always_comb begin
    m_sum = 9'd0;
    m_v   = 1'b0;
    case (ALU_sel)
      OP_ADD: begin
        m_sum = {1'b0, operand1} + {1'b0, operand2};
        m_v   = (operand1[7] == operand2[7]) && (m_sum[7] != operand1[7]);
      end
      OP_SUB, OP_CMP: begin
        m_sum = {1'b0, operand1} - {1'b0, operand2};
        m_v   = (operand1[7] != operand2[7]) && (m_sum[7] != operand1[7]);
      end
      OP_INC:  m_sum = {1'b0, operand1} + 9'd1;
      OP_DEC:  m_sum = {1'b0, operand1} - 9'd1;
      default: m_sum = 9'd0;
    endcase
    m_res = m_sum[7:0];
  end

  always @(posedge clk) begin
    alu_result <= m_res;
    alu_flags  <= {m_v, 1'b0, 1'b0, ~^m_res, m_res[7], m_sum[8], (m_res == 8'h00)};
    alu_eq     <= (operand1 == operand2);
    alu_gt     <= (operand1 > operand2);
    alu_lt     <= (operand1 < operand2);
  end

  // Present one request for a single accept edge; returns at the negedge after it.
  task automatic issue(input logic [7:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] dst);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_dst = dst;
    @(negedge clk);
    accept_cyc = cyc;
    req_valid = 1'b0;
  endtask

  // Bounded wait for done; latency is edges from accept to the done edge.
  task automatic wait_done(output bit ok, output int lat);
    ok = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        lat = cyc - accept_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || wb_en !== 1'b0)
      $display("FAIL reset_ctl: ready=%b done=%b err=%b wb_en=%b required 1 0 0 0",
               req_ready, done, err, wb_en);
    else passed++;
    checks++;
    if (operand1 !== 8'h00 || operand2 !== 8'h00 || ALU_sel !== 8'h00)
      $display("FAIL reset_alu_in: op1=%h op2=%h sel=%h required 00 00 00",
               operand1, operand2, ALU_sel);
    else passed++;
    checks++;
    if (wb_addr !== 3'd0 || wb_data !== 8'h00 || flags_q !== 7'b0001001 || cmp_q !== 3'b000)
      $display("FAIL reset_regs: addr=%0d data=%h flags=%b cmp=%b required 0 00 0001001 000",
               wb_addr, wb_data, flags_q, cmp_q);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic;
    bit ok; int lat; int wb0;
    wb0 = wb_seen;
    issue(OP_ADD, 8'h05, 8'h03, 3'd2);
    checks++;
    if (req_ready !== 1'b0 || ALU_sel !== OP_ADD || operand1 !== 8'h05 || operand2 !== 8'h03)
      $display("FAIL add_drive: ready=%b sel=%h op1=%h op2=%h required 0 03 05 03",
               req_ready, ALU_sel, operand1, operand2);
    else passed++;
    wait_done(ok, lat);
    checks++;
    if (!ok || lat != 3) $display("FAIL add_latency: ok=%0d lat=%0d required 1 3", ok, lat);
    else passed++;
    checks++;
    if (wb_en !== 1'b1 || wb_addr !== 3'd2 || wb_data !== 8'h08)
      $display("FAIL add_wb: wb_en=%b addr=%0d data=%h required 1 2 08", wb_en, wb_addr, wb_data);
    else passed++;
    checks++;
    if (flags_q[FLAG_Z] !== 1'b0 || flags_q[FLAG_C] !== 1'b0 || flags_q[FLAG_V] !== 1'b0)
      $display("FAIL add_flags: flags=%b required Z=0 C=0 V=0", flags_q);
    else passed++;
    checks++;
    if (ALU_sel !== OP_NOP || operand1 !== 8'h05 || operand2 !== 8'h03 || req_ready !== 1'b1)
      $display("FAIL add_idle_hold: sel=%h op1=%h op2=%h ready=%b required 00 05 03 1",
               ALU_sel, operand1, operand2, req_ready);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (wb_en !== 1'b0 || done !== 1'b0 || wb_seen - wb0 != 1)
      $display("FAIL add_single_pulse: wb_en=%b done=%b pulses=%0d required 0 0 1",
               wb_en, done, wb_seen - wb0);
    else passed++;
  endtask

  task automatic test_add_carry;
    bit ok; int lat;
    issue(OP_ADD, 8'hFF, 8'h01, 3'd1);
    wait_done(ok, lat);
    checks++;
    if (!ok || wb_en !== 1'b1 || wb_addr !== 3'd1 || wb_data !== 8'h00)
      $display("FAIL carry_wb: ok=%0d wb_en=%b addr=%0d data=%h required 1 1 1 00",
               ok, wb_en, wb_addr, wb_data);
    else passed++;
    checks++;
    if (flags_q !== 7'b0001011)
      $display("FAIL carry_flags: flags=%b required 0001011", flags_q);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int wb0;
    wb0 = wb_seen;
    issue(8'h01, 8'h12, 8'h34, 3'd6);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || wb_en !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL illegal_pulse: done=%b err=%b wb_en=%b ready=%b required 1 1 0 1",
               done, err, wb_en, req_ready);
    else passed++;
    checks++;
    if (flags_q !== 7'b0001011 || ALU_sel !== OP_NOP || operand1 !== 8'hFF)
      $display("FAIL illegal_noupd: flags=%b sel=%h op1=%h required 0001011 00 ff",
               flags_q, ALU_sel, operand1);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || wb_seen != wb0)
      $display("FAIL illegal_end: done=%b err=%b wb_pulses=%0d required 0 0 0",
               done, err, wb_seen - wb0);
    else passed++;
  endtask

  task automatic test_cmp;
    bit ok; int lat; int wb0;
    wb0 = wb_seen;
    issue(OP_CMP, 8'h07, 8'h07, 3'd3);
    wait_done(ok, lat);
    checks++;
    if (!ok || lat != 3 || err !== 1'b0 || wb_en !== 1'b0)
      $display("FAIL cmp_eq_done: ok=%0d lat=%0d err=%b wb_en=%b required 1 3 0 0",
               ok, lat, err, wb_en);
    else passed++;
    checks++;
    if (cmp_q !== 3'b100 || flags_q[FLAG_Z] !== 1'b1)
      $display("FAIL cmp_eq_val: cmp=%b z=%b required 100 1", cmp_q, flags_q[FLAG_Z]);
    else passed++;
    @(negedge clk);
    issue(OP_CMP, 8'h09, 8'h03, 3'd3);
    wait_done(ok, lat);
    checks++;
    if (!ok || cmp_q !== 3'b010 || flags_q[FLAG_Z] !== 1'b0 || wb_seen != wb0)
      $display("FAIL cmp_gt: ok=%0d cmp=%b z=%b wb_pulses=%0d required 1 010 0 0",
               ok, cmp_q, flags_q[FLAG_Z], wb_seen - wb0);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n; int c0; int c1; logic [7:0] d0; logic [7:0] d1; bit drop;
    n = 0; c0 = 0; c1 = 0; d0 = 8'h00; d1 = 8'h00; drop = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = OP_INC; req_a = 8'h7F; req_b = 8'h00; req_dst = 3'd3;
    @(negedge clk);
    // Second request waits on the bus while the first one is in flight.
    req_op = OP_DEC; req_a = 8'h00; req_dst = 3'd4;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (wb_en) begin
        if (n == 0) begin c0 = cyc; d0 = wb_data; drop = 1'b1; end
        else if (n == 1) begin c1 = cyc; d1 = wb_data; end
        n++;
      end else if (drop) begin
        req_valid = 1'b0;
        drop = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (n != 2 || c1 - c0 != 4)
      $display("FAIL b2b_pulses: count=%0d spacing=%0d required 2 4", n, c1 - c0);
    else passed++;
    checks++;
    if (d0 !== 8'h80 || d1 !== 8'hFF)
      $display("FAIL b2b_data: first=%h second=%h required 80 ff", d0, d1);
    else passed++;
    checks++;
    if (cmp_q !== 3'b010 || wb_addr !== 3'd4)
      $display("FAIL b2b_state: cmp=%b addr=%0d required 010 4", cmp_q, wb_addr);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok; int lat; int wb0; int d0;
    issue(OP_SUB, 8'h10, 8'h03, 3'd5);
    @(negedge clk);
    rst_n = 1'b0;
    wb0 = wb_seen; d0 = done_seen;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || operand1 !== 8'h00 || operand2 !== 8'h00 || ALU_sel !== 8'h00 ||
        wb_addr !== 3'd0 || wb_data !== 8'h00 || flags_q !== 7'b0001001 || cmp_q !== 3'b000 ||
        wb_en !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL midreset_vals: ready=%b op1=%h op2=%h sel=%h addr=%0d data=%h flags=%b cmp=%b required reset values",
               req_ready, operand1, operand2, ALU_sel, wb_addr, wb_data, flags_q, cmp_q);
    else passed++;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (wb_seen != wb0 || done_seen != d0)
      $display("FAIL midreset_abort: wb_pulses=%0d done_pulses=%0d required 0 0",
               wb_seen - wb0, done_seen - d0);
    else passed++;
    issue(OP_SUB, 8'h10, 8'h03, 3'd5);
    wait_done(ok, lat);
    checks++;
    if (!ok || lat != 3 || wb_en !== 1'b1 || wb_addr !== 3'd5 || wb_data !== 8'h0D)
      $display("FAIL midreset_next: ok=%0d lat=%0d wb_en=%b addr=%0d data=%h required 1 3 1 5 0d",
               ok, lat, wb_en, wb_addr, wb_data);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add_basic;
    test_add_carry;
    test_illegal;
    test_cmp;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
